// File: rtl/fetch_pkg.sv
// Shared fetch-front-end constants, queue entry layout and pointer-width helper.
// Optional FETCH_ALIGN_CHECK_EN adds a misaligned-redirect exception entry.
package fetch_pkg;
  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
  localparam int          DEF_PC_STEP = 4;
  localparam int          DEF_AW      = 32;
  localparam int          DEF_DW      = 32;

  typedef struct packed {
    logic [DEF_AW-1:0] pc;
    logic [DEF_DW-1:0] inst;
    logic              filled;
    logic              exc;
  } fetch_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: allocate at tail, fill oldest unfilled, pop at head, flush.
// With FETCH_ALIGN_CHECK_EN a flush can seed one pre-filled exception entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc,
  input  logic [AW-1:0] alloc_pc,
  input  logic          fill,
  input  logic [DW-1:0] fill_data,
  input  logic          pop,
`ifdef FETCH_ALIGN_CHECK_EN
  input  logic          exc_push,
  input  logic [AW-1:0] exc_pc,
  output logic          head_exc,
`endif
  output logic [PW:0]   count,
  output logic [PW:0]   unfilled,
  output logic          head_valid,
  output logic [AW-1:0] head_pc,
  output logic [DW-1:0] head_inst
);
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic          filled;
`ifdef FETCH_ALIGN_CHECK_EN
    logic          exc;
`endif
  } entry_t;

  entry_t      mem [DEPTH];
  logic [PW:0] head, tail, fptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      fptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      fptr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (exc_push) begin
        mem[0].pc     <= exc_pc;
        mem[0].inst   <= '0;
        mem[0].filled <= 1'b1;
        mem[0].exc    <= 1'b1;
        tail          <= (PW+1)'(1);
        fptr          <= (PW+1)'(1);
      end
`endif
    end else begin
      if (alloc) begin
        mem[tail[PW-1:0]].pc     <= alloc_pc;
        mem[tail[PW-1:0]].filled <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        mem[tail[PW-1:0]].exc    <= 1'b0;
`endif
        tail <= tail + (PW+1)'(1);
      end
      // fptr never equals the tail slot being allocated unless nothing is outstanding
      if (fill && fptr != tail) begin
        mem[fptr[PW-1:0]].inst   <= fill_data;
        mem[fptr[PW-1:0]].filled <= 1'b1;
        fptr <= fptr + (PW+1)'(1);
      end
      if (pop) head <= head + (PW+1)'(1);
    end
  end

  assign count      = tail - head;
  assign unfilled   = tail - fptr;
  assign head_valid = (head != tail) && mem[head[PW-1:0]].filled;
  assign head_pc    = mem[head[PW-1:0]].pc;
  assign head_inst  = mem[head[PW-1:0]].inst;
`ifdef FETCH_ALIGN_CHECK_EN
  assign head_exc   = mem[head[PW-1:0]].exc;
`endif
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, imem request/grant issue, stale-response drop.
// FETCH_ALIGN_CHECK_EN turns misaligned redirects into a single exception entry and halts fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] INIT_PC     = ADDR_WIDTH'(RESET_PC),
  parameter int                    QUEUE_DEPTH = 4,
  parameter int                    PC_STEP     = DEF_PC_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_exc
);
  localparam int PW = clog2(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc, head_pc;
  logic [DATA_WIDTH-1:0] head_inst;
  logic [PW:0]           drop_cnt, q_count, q_unfilled, pend;
  logic [PW+1:0]         inflight;
  logic                  issue, rsp_drop, rsp_fill, pop, head_valid, halted;

  // Dropped-but-unreturned requests still occupy the in-flight budget so drop_cnt cannot overflow
  assign inflight = {1'b0, q_count} + {1'b0, drop_cnt};
  assign pend     = drop_cnt + q_unfilled;
  assign imem_req = !rst && !redirect_valid && !halted && (inflight < (PW+2)'(QUEUE_DEPTH));
  assign imem_addr = fetch_pc;
  assign issue    = imem_req && imem_gnt;
  assign rsp_drop = imem_rvalid && (drop_cnt != '0);
  assign rsp_fill = imem_rvalid && (drop_cnt == '0);
  assign out_valid = !rst && head_valid && !redirect_valid;
  assign pop      = out_valid && out_ready;
  assign out_pc   = rst ? '0 : head_pc;
  assign out_inst = rst ? '0 : head_inst;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned, head_exc;
  assign misaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);
  assign out_exc    = !rst && head_exc;
`else
  assign halted  = 1'b0;
  assign out_exc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= INIT_PC;
      drop_cnt <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      halted   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= redirect_addr;
      // a response landing in the redirect cycle is discarded here, not counted
      drop_cnt <= pend - (PW+1)'(imem_rvalid && (pend != '0));
`ifdef FETCH_ALIGN_CHECK_EN
      halted   <= misaligned;
`endif
    end else begin
      if (issue)    fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
      if (rsp_drop) drop_cnt <= drop_cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rvalid) assert (pend != '0);
  end

  fetch_queue #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (issue),
    .alloc_pc   (fetch_pc),
    .fill       (rsp_fill),
    .fill_data  (imem_rdata),
    .pop        (pop),
`ifdef FETCH_ALIGN_CHECK_EN
    .exc_push   (misaligned),
    .exc_pc     (redirect_addr),
    .head_exc   (head_exc),
`endif
    .count      (q_count),
    .unfilled   (q_unfilled),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst)
  );
endmodule
